compare_sweep_driver: RTL and testbench

Synthesizable stimulus/check engine for a 4-bit constant comparator. It drives the comparator's value input and reads back its equality output. On a start pulse it sweeps every input value 0..2^WIDTH-1 and waits a settle time per value. It then checks the comparator's output against the expected result (value == TARGET), counts mismatches and records the first failing value. It sits on the driving side of the comparator and is used for on-board self-test of lab combinational blocks.

---
 rtl/compare_sweep_driver.sv | 123 ++++++++++++
 tb/tb_compare_sweep_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/compare_sweep_driver.sv
// Sweeps 0..2^WIDTH-1 into a constant comparator and checks eq_in against value == TARGET.
// Latency: SETTLE_CYCLES+1 cycles per value; there is no backpressure, and start is ignored while busy.
module compare_sweep_driver #(
    parameter int WIDTH         = 4,
    parameter int TARGET        = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             eq_in,
    output logic [WIDTH-1:0] num_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] fail_num,
    output logic             fail_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam int               CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] TGT      = WIDTH'(TARGET);
    localparam logic [WIDTH-1:0] NUM_LAST = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   err_q, err_d;
    logic [WIDTH-1:0] fail_num_q, fail_num_d;
    logic             fail_vld_q, fail_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fail_num_d = fail_num_q;
        fail_vld_d = fail_vld_q;
        mismatch   = (eq_in != (num_q == TGT));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d      = '0;
                    cnt_d      = '0;
                    err_d      = '0;
                    fail_num_d = '0;
                    fail_vld_d = 1'b0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + (WIDTH+1)'(1);
                    if (!fail_vld_q) begin
                        fail_num_d = num_q;
                        fail_vld_d = 1'b1;
                    end
                end
                // Last value: hold num_out so it reads 2^WIDTH-1 in DONE
                if (num_q == NUM_LAST) begin
                    state_d = DONE;
                end else begin
                    num_d   = num_q + WIDTH'(1);
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            num_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            fail_num_q <= '0;
            fail_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            fail_num_q <= fail_num_d;
            fail_vld_q <= fail_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign num_out    = num_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_num   = fail_num_q;
    assign fail_valid = fail_vld_q;

endmodule

// File: tb/tb_compare_sweep_driver.sv
// Bench for compare_sweep_driver: a default instance and a SETTLE_CYCLES=3 instance, each driving a behavioural comparator.
// Expected sweep results are queued at start; monitors pop and compare them when done rises.
module tb_compare_sweep_driver;

    typedef struct {
        int   start_cyc;
        int   lat;
        int   err;
        int   fnum;
        logic fv;
        logic pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       eq_a, eq_b;
    logic [3:0] num_a, num_b;
    logic       busy_a, done_a, pass_a, fv_a;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [4:0] err_a, err_b;
    logic [3:0] fnum_a, fnum_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   mode_a  = 0;
    int   busy_cnt_a = 0;
    int   chg_b   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: correct (==3), 1: stuck 0, 2: wrong constant (==5), 3: stuck 1
    always_comb begin
        case (mode_a)
            0:       eq_a = (num_a == 4'd3);
            1:       eq_a = 1'b0;
            2:       eq_a = (num_a == 4'd5);
            default: eq_a = 1'b1;
        endcase
        eq_b = (num_b == 4'd3);
    end

    compare_sweep_driver u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .eq_in(eq_a), .num_out(num_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_num(fnum_a), .fail_valid(fv_a)
    );

    compare_sweep_driver #(.WIDTH(4), .TARGET(3), .SETTLE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .eq_in(eq_b), .num_out(num_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_num(fnum_b), .fail_valid(fv_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " num_out"},    int'(num_a),  0);
        check({tag, " busy"},       int'(busy_a), 0);
        check({tag, " done"},       int'(done_a), 0);
        check({tag, " pass"},       int'(pass_a), 0);
        check({tag, " err_count"},  int'(err_a),  0);
        check({tag, " fail_num"},   int'(fnum_a), 0);
        check({tag, " fail_valid"}, int'(fv_a),   0);
    endtask

    task automatic start_a_sweep(input int lat, input int err, input int fnum,
                                 input logic fv, input logic pass);
        exp_t e;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        e.start_cyc = cyc; e.lat = lat; e.err = err; e.fnum = fnum; e.fv = fv; e.pass = pass;
        q_a.push_back(e);
        check("accept busy", int'(busy_a), 1);
        check("accept done", int'(done_a), 0);
        check("accept pass", int'(pass_a), 0);
    endtask

    task automatic wait_done_a(input string name, input int limit);
        int i;
        for (i = 0; i < limit && !done_a; i++) @(negedge clk);
        if (!done_a) check({name, " done timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_num_a(input int val, input int limit);
        int i;
        for (i = 0; i < limit && int'(num_a) != val; i++) @(negedge clk);
        if (int'(num_a) != val) check("wait num_out timeout", int'(num_a), val);
    endtask

    // Monitor for instance A
    initial begin
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) busy_cnt_a = 0;
            else if (busy_a) busy_cnt_a++;
            if (done_a && !done_prev) begin
                if (q_a.size() == 0) begin
                    check("A unexpected done", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("A latency",    cyc - e.start_cyc, e.lat);
                    check("A busy cycles", busy_cnt_a,       e.lat);
                    check("A err_count",  int'(err_a),       e.err);
                    check("A fail_valid", int'(fv_a),        int'(e.fv));
                    check("A fail_num",   int'(fnum_a),      e.fnum);
                    check("A pass",       int'(pass_a),      int'(e.pass));
                    check("A num_out",    int'(num_a),       15);
                    check("A busy",       int'(busy_a),      0);
                end
                busy_cnt_a = 0;
            end
            done_prev = done_a;
        end
    end

    // Monitor for instance B, including the hold time of each value
    initial begin
        logic done_prev = 1'b0;
        logic [3:0] last_num = 4'd0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && num_b != last_num) begin
                check("B num_out hold interval", cyc - chg_b, 4);
                chg_b = cyc;
            end
            last_num = num_b;
            if (done_b && !done_prev) begin
                if (q_b.size() == 0) begin
                    check("B unexpected done", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("B latency",    cyc - e.start_cyc, e.lat);
                    check("B err_count",  int'(err_b),       e.err);
                    check("B fail_valid", int'(fv_b),        int'(e.fv));
                    check("B pass",       int'(pass_b),      int'(e.pass));
                    check("B num_out",    int'(num_b),       15);
                end
            end
            done_prev = done_b;
        end
    end

    initial begin
        exp_t e;
        int   i;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Correct comparator
        mode_a = 0;
        start_a_sweep(32, 0, 0, 1'b0, 1'b1);
        wait_done_a("correct", 40);

        // Output stuck at 0: only value 3 mismatches
        mode_a = 1;
        start_a_sweep(32, 1, 3, 1'b1, 1'b0);
        wait_done_a("stuck0", 40);

        // Wrong constant: values 3 and 5 mismatch, first one recorded
        mode_a = 2;
        start_a_sweep(32, 2, 3, 1'b1, 1'b0);
        wait_done_a("wrong const", 40);

        // Stuck at 1: all but 3 mismatch
        mode_a = 3;
        start_a_sweep(32, 15, 0, 1'b1, 1'b0);
        wait_done_a("stuck1", 40);

        // Restart from DONE with a correct model clears the error record
        mode_a = 0;
        start_a_sweep(32, 0, 0, 1'b0, 1'b1);
        wait_done_a("restart", 40);

        // Extra start pulses mid-sweep are ignored
        start_a_sweep(32, 0, 0, 1'b0, 1'b1);
        wait_num_a(4, 40);
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        start_a = 1'b0;
        check("ignored start busy", int'(busy_a), 1);
        wait_done_a("ignored start", 40);

        // Reset mid-sweep at num_out = 7
        start_a_sweep(32, 0, 0, 1'b0, 1'b1);
        wait_num_a(7, 40);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q_a.delete();
        check_reset_state("mid-sweep reset");
        repeat (6) @(negedge clk);
        check("idle after reset busy",    int'(busy_a), 0);
        check("idle after reset done",    int'(done_a), 0);
        check("idle after reset num_out", int'(num_a),  0);

        start_a_sweep(32, 0, 0, 1'b0, 1'b1);
        wait_done_a("after reset", 40);

        // SETTLE_CYCLES = 3 instance
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        chg_b = cyc;
        e.start_cyc = cyc; e.lat = 64; e.err = 0; e.fnum = 0; e.fv = 1'b0; e.pass = 1'b1;
        q_b.push_back(e);
        check("B accept busy", int'(busy_b), 1);
        for (i = 0; i < 80 && !done_b; i++) @(negedge clk);
        if (!done_b) check("B done timeout", 0, 1);
        repeat (2) @(negedge clk);

        check("A scoreboard drained", q_a.size(), 0);
        check("B scoreboard drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
